// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-stage register: payload width limit and
// the occupancy state encoding used by the stage controller.
package pipe_stage_reg_pkg;

  localparam int MAX_LENGTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy control for one pipeline stage: tracks how many beats are held,
// produces the handshake outputs and the load enables for the data registers.
module pipe_stage_ctrl
  import pipe_stage_reg_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] count,
  output logic       load_main,
  output logic       load_skid,
  output logic       main_sel_skid
);

  if (SKID != 0) begin : g_skid
    state_e state, state_next;
    logic   in_ready_q;
    logic   accept, fire;

    assign accept = in_valid & in_ready_q;
    assign fire   = (state != ST_EMPTY) & out_ready;

    // NOTE: non-blocking assignments for every flop so all state updates see
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
      if (reset) begin
        state      <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state      <= state_next;
        in_ready_q <= (state_next != ST_TWO);
      end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
      state_next    = state;
      load_main     = 1'b0;
      load_skid     = 1'b0;
      main_sel_skid = 1'b0;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = ST_TWO;
            load_skid  = 1'b1;
          end else if (fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (fire) begin
            state_next    = ST_ONE;
            load_main     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
      // Flush only clears validity; data registers are left untouched.
      if (flush) begin
        state_next = ST_EMPTY;
        load_main  = 1'b0;
        load_skid  = 1'b0;
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign count     = state;
  end else begin : g_single
    logic valid_q;
    logic accept, fire;

    assign in_ready = out_ready | ~valid_q;
    assign accept   = in_valid & in_ready;
    assign fire     = valid_q & out_ready;

    always_ff @(posedge clk) begin
      if (reset || flush) valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (fire)      valid_q <= 1'b0;
    end

    assign load_main     = accept & ~flush;
    assign load_skid     = 1'b0;
    assign main_sel_skid = 1'b0;
    assign out_valid     = valid_q;
    assign count         = {1'b0, valid_q};
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with stall, flush and an optional
// two-entry skid buffer; main always holds the oldest beat.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = MAX_LENGTH,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main, load_skid, main_sel_skid;

  pipe_stage_ctrl #(.SKID(SKID)) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .count        (count),
    .load_main    (load_main),
    .load_skid    (load_skid),
    .main_sel_skid(main_sel_skid)
  );

  // NOTE: the data registers are reset as well, because out_data must show
  // RESET_VAL straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (load_main) main_q <= main_sel_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector tables for SKID=1 and SKID=0,
// hand sequences for reset corners, then randomized traffic against queue models.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV1 = 32'hDEAD_BEEF;
  localparam logic [31:0] RV0 = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_count;
  logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_VAL(RV1)) dut_s (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .count(s_count)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .RESET_VAL(RV0)) dut_n (
    .clk(clk), .reset(reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_data(n_in_data), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_ready(n_out_ready),
    .count(n_count)
  );

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_count;
    logic        exp_in_ready;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic ev, input logic [31:0] ed,
                              input logic [1:0] ec, input logic eir);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec; v.exp_in_ready = eir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0;
    n_flush = 0; n_in_valid = 0; n_in_data = '0; n_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_s(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(s_out_valid), 32'(v.exp_valid));
    check({tag, ".count"}, 32'(s_count), 32'(v.exp_count));
    check({tag, ".in_ready"}, 32'(s_in_ready), 32'(v.exp_in_ready));
    if (v.exp_valid) check({tag, ".data"}, s_out_data, v.exp_data);
  endtask

  task automatic check_n(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(n_out_valid), 32'(v.exp_valid));
    check({tag, ".count"}, 32'(n_count), 32'(v.exp_count));
    check({tag, ".in_ready"}, 32'(n_in_ready), 32'(v.exp_in_ready));
    if (v.exp_valid) check({tag, ".data"}, n_out_data, v.exp_data);
  endtask

  vec_t s_tab[$];
  vec_t n_tab[$];
  logic [31:0] s_q[$];
  logic [31:0] n_q[$];

  initial begin
    // Skid stage: stream, stall into TWO, drain, flush on accept, flush in TWO.
    for (int k = 1; k <= 8; k++) s_tab.push_back(mk(0, 1, k, 1, 1, k, 1, 1));
    s_tab.push_back(mk(0, 0, 0,     1, 0, 0,     0, 1));
    s_tab.push_back(mk(0, 1, 'hA,   0, 1, 'hA,   1, 1));
    s_tab.push_back(mk(0, 1, 'hB,   0, 1, 'hA,   2, 0));
    s_tab.push_back(mk(0, 1, 'hD,   0, 1, 'hA,   2, 0));
    s_tab.push_back(mk(0, 0, 0,     1, 1, 'hB,   1, 1));
    s_tab.push_back(mk(0, 0, 0,     1, 0, 0,     0, 1));
    s_tab.push_back(mk(0, 1, 'h7,   0, 1, 'h7,   1, 1));
    s_tab.push_back(mk(1, 1, 'hC,   0, 0, 0,     0, 1));
    s_tab.push_back(mk(0, 0, 0,     1, 0, 0,     0, 1));
    s_tab.push_back(mk(0, 1, 'h11,  0, 1, 'h11,  1, 1));
    s_tab.push_back(mk(0, 1, 'h12,  0, 1, 'h11,  2, 0));
    s_tab.push_back(mk(1, 0, 0,     0, 0, 0,     0, 1));
    s_tab.push_back(mk(0, 1, 'h13,  1, 1, 'h13,  1, 1));

    // Single-entry stage: stall blocks in_ready, replace-in-place, flush.
    n_tab.push_back(mk(0, 1, 'h5, 0, 1, 'h5, 1, 0));
    n_tab.push_back(mk(0, 1, 'h6, 0, 1, 'h5, 1, 0));
    n_tab.push_back(mk(0, 1, 'h6, 1, 1, 'h6, 1, 1));
    n_tab.push_back(mk(0, 1, 'h7, 1, 1, 'h7, 1, 1));
    n_tab.push_back(mk(0, 0, 0,   1, 0, 0,   0, 1));
    n_tab.push_back(mk(0, 1, 'h8, 0, 1, 'h8, 1, 0));
    n_tab.push_back(mk(1, 0, 0,   0, 0, 0,   0, 1));
    n_tab.push_back(mk(1, 1, 'h9, 1, 0, 0,   0, 1));
    n_tab.push_back(mk(0, 0, 0,   0, 0, 0,   0, 1));

    do_reset();
    check("reset_s.valid", 32'(s_out_valid), 0);
    check("reset_s.data", s_out_data, RV1);
    check("reset_s.count", 32'(s_count), 0);
    check("reset_s.in_ready", 32'(s_in_ready), 1);
    check("reset_n.valid", 32'(n_out_valid), 0);
    check("reset_n.data", n_out_data, RV0);
    check("reset_n.count", 32'(n_count), 0);
    check("reset_n.in_ready", 32'(n_in_ready), 1);
    reset = 1'b0;

    foreach (s_tab[i]) begin
      s_flush = s_tab[i].flush; s_in_valid = s_tab[i].in_valid;
      s_in_data = s_tab[i].in_data; s_out_ready = s_tab[i].out_ready;
      tick();
      check_s($sformatf("s_vec%0d", i), s_tab[i]);
    end
    foreach (n_tab[i]) begin
      n_flush = n_tab[i].flush; n_in_valid = n_tab[i].in_valid;
      n_in_data = n_tab[i].in_data; n_out_ready = n_tab[i].out_ready;
      tick();
      check_n($sformatf("n_vec%0d", i), n_tab[i]);
    end

    // Reset while the skid stage is full: both beats are lost.
    idle_all();
    s_in_valid = 1; s_in_data = 'h21; tick();
    s_in_data = 'h22; tick();
    check("stall_full.count", 32'(s_count), 2);
    s_in_valid = 0; reset = 1'b1; s_flush = 1'b1; tick();
    reset = 1'b0; s_flush = 1'b0;
    check("rst_full.count", 32'(s_count), 0);
    check("rst_full.in_ready", 32'(s_in_ready), 1);
    check("rst_full.data", s_out_data, RV1);
    s_out_ready = 1; tick();
    check("rst_full.drained", 32'(s_out_valid), 0);

    // Randomized traffic against queue models of capacity 2 and 1.
    idle_all();
    s_q.delete(); n_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit s_acc, s_fire, n_acc, n_fire;
      reset       = ($urandom_range(999) == 0);
      s_flush     = ($urandom_range(31) == 0);
      n_flush     = ($urandom_range(31) == 0);
      s_in_valid  = ($urandom_range(3) != 0);
      n_in_valid  = ($urandom_range(3) != 0);
      s_out_ready = ($urandom_range(1) == 0);
      n_out_ready = ($urandom_range(1) == 0);
      s_in_data   = $urandom;
      n_in_data   = $urandom;

      s_acc  = s_in_valid && (s_q.size() < 2);
      s_fire = s_out_ready && (s_q.size() > 0);
      n_acc  = n_in_valid && (n_out_ready || n_q.size() == 0);
      n_fire = n_out_ready && (n_q.size() > 0);

      tick();

      if (reset || s_flush) s_q.delete();
      else begin
        if (s_fire) void'(s_q.pop_front());
        if (s_acc) s_q.push_back(s_in_data);
      end
      if (reset || n_flush) n_q.delete();
      else begin
        if (n_fire) void'(n_q.pop_front());
        if (n_acc) n_q.push_back(n_in_data);
      end

      check("rnd_s.valid", 32'(s_out_valid), 32'(s_q.size() > 0));
      check("rnd_s.count", 32'(s_count), 32'(s_q.size()));
      check("rnd_s.in_ready", 32'(s_in_ready), 32'(s_q.size() < 2));
      if (s_q.size() > 0) check("rnd_s.data", s_out_data, s_q[0]);
      check("rnd_n.valid", 32'(n_out_valid), 32'(n_q.size() > 0));
      check("rnd_n.count", 32'(n_count), 32'(n_q.size()));
      check("rnd_n.in_ready", 32'(n_in_ready), 32'(n_out_ready || n_q.size() == 0));
      if (n_q.size() > 0) check("rnd_n.data", n_out_data, n_q[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
